// File: rtl/da_tx.sv
// Serial DAC transmitter: shifts a DATA_W word MSB first on daclk with an
// active-low chip select; every output comes straight from a register.
module da_tx #(
  parameter int DATA_W = 8,
  parameter int HALF   = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              dacs,
  output logic              daclk,
  output logic              dadata,
  output logic              busy,
  output logic              done
);

  localparam int DVW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t            state_reg;
  logic [DVW-1:0]    div_reg;
  logic [BW-1:0]     bit_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              div_end;
  logic              last_bit;
  logic              all_sent;

  assign shift_next = shift_reg << 1;
  assign div_end    = (div_reg == DVW'(HALF - 1));
  assign last_bit   = (bit_reg == BW'(DATA_W - 1));
  assign all_sent   = (bit_reg == BW'(DATA_W));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      dacs      <= 1'b1;
      daclk     <= 1'b0;
      dadata    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SETUP;
            shift_reg <= din;
            dadata    <= din[DATA_W-1];
            dacs      <= 1'b0;
            busy      <= 1'b1;
            div_reg   <= '0;
            bit_reg   <= '0;
          end
        end
        SETUP: begin
          if (div_end) begin
            state_reg <= HIGH;
            daclk     <= 1'b1;
            div_reg   <= '0;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        HIGH: begin
          if (div_end) begin
            state_reg <= LOW;
            daclk     <= 1'b0;
            div_reg   <= '0;
            bit_reg   <= bit_reg + 1'b1;
            // Next bit is launched on the falling edge; after the last bit the
            // final LOW phase holds dadata so the DAC hold time is met.
            if (!last_bit) begin
              shift_reg <= shift_next;
              dadata    <= shift_next[DATA_W-1];
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        LOW: begin
          if (div_end) begin
            div_reg <= '0;
            if (all_sent) begin
              state_reg <= GAP;
              dacs      <= 1'b1;
              dadata    <= 1'b0;
            end else begin
              state_reg <= HIGH;
              daclk     <= 1'b1;
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        GAP: begin
          if (div_end) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          dacs      <= 1'b1;
          daclk     <= 1'b0;
          dadata    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
